axi_slave_write_burst: RTL and testbench

//  Parametrised AXI write-channel slave front end for one single-port SRAM bank.

---
 rtl/axi_slave_write_burst.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_slave_write_burst.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_write_burst.sv
// AXI write-channel slave front end for one single-port SRAM bank.
// Accepts one AW at a time, turns each W beat into a byte-masked SRAM write,
// then returns B. FIXED and INCR bursts are always supported.
// WRAP bursts are supported only when AXI_WRAP_BURST_EN is defined; otherwise
// AWBURST=10 is rejected with SLVERR like the reserved encoding 11.
module axi_slave_write_burst #(
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int SRAM_AW   = 14
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ID_BITS-1:0]     AWID,
    input  logic [ADDR_BITS-1:0]   AWADDR,
    input  logic [LEN_BITS-1:0]    AWLEN,
    input  logic [2:0]             AWSIZE,
    input  logic [1:0]             AWBURST,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [DATA_BITS-1:0]   WDATA,
    input  logic [DATA_BITS/8-1:0] WSTRB,
    input  logic                   WLAST,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [ID_BITS-1:0]     BID,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic                   grant,
    output logic                   finish,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [DATA_BITS/8-1:0] sram_web,
    output logic [DATA_BITS-1:0]   sram_wdata
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int SB        = $clog2(STRB_BITS);
    // Byte-address bits that fall inside the bank; anything above is out of range.
    localparam int BANK_BITS = SRAM_AW + SB;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [ID_BITS-1:0]   id_q, id_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    // One bit wider than AWLEN so beats past the declared length stay countable.
    logic [LEN_BITS:0]    beat_q, beat_d;
    logic                 err_q, err_d;

    logic [ADDR_BITS-1:0] step;
    logic [ADDR_BITS-1:0] next_incr;
    logic [ADDR_BITS-1:0] next_addr;
    logic [LEN_BITS:0]    beat_len;
    logic                 beat_oob;
    logic                 aw_size_err;
    logic                 aw_addr_err;
    logic                 aw_burst_err;
    logic                 aw_err;

`ifdef AXI_WRAP_BURST_EN
    logic [ADDR_BITS-1:0] wrap_mask;
    logic [ADDR_BITS-1:0] next_wrap;
    logic [ADDR_BITS-1:0] aw_align_mask;

    // Legal WRAP lengths are 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [LEN_BITS-1:0] len);
        logic [31:0] l;
        l = 32'(len);
        return (l == 32'd1) || (l == 32'd3) || (l == 32'd7) || (l == 32'd15);
    endfunction
`endif

    assign beat_len   = {1'b0, len_q};
    assign beat_oob   = (addr_q >> BANK_BITS) != '0;
    assign sram_addr  = addr_q[BANK_BITS-1:SB];
    assign BID        = id_q;
    assign BRESP      = err_q ? RESP_SLVERR : RESP_OKAY;

    // Address of the beat after the current one, by burst type.
    always_comb begin
        step      = ADDR_ONE << size_q;
        next_incr = addr_q + step;
`ifdef AXI_WRAP_BURST_EN
        wrap_mask = (({{(ADDR_BITS-LEN_BITS){1'b0}}, len_q} + ADDR_ONE) << size_q) - ADDR_ONE;
        next_wrap = ((next_incr & wrap_mask) == '0) ? (addr_q & ~wrap_mask) : next_incr;
`endif
        case (burst_q)
            BURST_INCR: next_addr = next_incr;
`ifdef AXI_WRAP_BURST_EN
            BURST_WRAP: next_addr = next_wrap;
`endif
            default:    next_addr = addr_q;
        endcase
    end

    // Reject malformed write requests up front; the burst then runs with writes suppressed.
    always_comb begin
        aw_size_err   = AWSIZE > 3'(SB);
        aw_addr_err   = (AWADDR >> BANK_BITS) != '0;
`ifdef AXI_WRAP_BURST_EN
        aw_align_mask = (ADDR_ONE << AWSIZE) - ADDR_ONE;
        aw_burst_err  = (AWBURST == 2'b11) ||
                        ((AWBURST == BURST_WRAP) &&
                         (!wrap_len_ok(AWLEN) || ((AWADDR & aw_align_mask) != '0)));
`else
        aw_burst_err  = AWBURST[1];
`endif
        aw_err        = aw_size_err || aw_addr_err || aw_burst_err;
    end

    // Handshake FSM plus the zero-latency SRAM write path.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        err_d      = err_q;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        finish     = 1'b0;
        sram_web   = '1;
        sram_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                AWREADY = grant;
                if (AWVALID && grant) begin
                    id_d    = AWID;
                    addr_d  = AWADDR;
                    len_d   = AWLEN;
                    size_d  = AWSIZE;
                    burst_d = AWBURST;
                    beat_d  = '0;
                    err_d   = aw_err;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    // The beat that reveals a length error is still written;
                    // only the beats after it are dropped.
                    if (!err_q && !beat_oob && (beat_q <= beat_len)) begin
                        sram_web = ~WSTRB;
                    end
                    sram_wdata = WDATA;
                    addr_d     = next_addr;
                    if (beat_q != '1) begin
                        beat_d = beat_q + 1'b1;
                    end
                    if (WLAST) begin
                        state_d = ST_RESP;
                        if (beat_q < beat_len) begin
                            err_d = 1'b1;
                        end
                    end else if (beat_q >= beat_len) begin
                        err_d = 1'b1;
                    end
                    if (beat_oob) begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_slave_write_burst.sv
// Directed bench for axi_slave_write_burst (default parameters).
// Build with +define+AXI_WRAP_BURST_EN to exercise WRAP support.
module tb_axi_slave_write_burst;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic        clock;
    logic        reset;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        grant;
    logic        finish;
    logic [13:0] sram_addr;
    logic [3:0]  sram_web;
    logic [31:0] sram_wdata;

    int checks;
    int errors;

    axi_slave_write_burst dut (
        .clock(clock), .reset(reset),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .grant(grant), .finish(finish),
        .sram_addr(sram_addr), .sram_web(sram_web), .sram_wdata(sram_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present AW until accepted (bounded), then drop AWVALID after the handshake edge.
    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output logic ok);
        int n;
        @(negedge clock);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        #1;
        while (!AWREADY && n < 10) begin
            @(negedge clock); #1; n++;
        end
        ok = AWREADY;
        @(posedge clock); #1;
        AWVALID = 1'b0;
    endtask

    // Drive one W beat and capture the SRAM side while the beat is on the bus.
    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          output logic rdy, output logic [13:0] a, output logic [3:0] web,
                          output logic [31:0] wd);
        @(negedge clock);
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        #1;
        rdy = WREADY; a = sram_addr; web = sram_web; wd = sram_wdata;
        @(posedge clock); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    // Wait (bounded) for BVALID, then take the response with BREADY.
    task automatic get_b(output logic got, output int waited, output logic [7:0] bid,
                         output logic [1:0] bresp, output logic fin);
        got = 1'b0; waited = 0; bid = '0; bresp = '0; fin = 1'b0;
        @(negedge clock); #1;
        while (!BVALID && waited < 20) begin
            @(negedge clock); #1; waited++;
        end
        got = BVALID;
        if (got) begin
            bid = BID; bresp = BRESP;
            BREADY = 1'b1;
            #1;
            fin = finish;
            @(posedge clock); #1;
            BREADY = 1'b0;
        end
    endtask

    task automatic test_reset;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; grant = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (WREADY !== 1'b0 || BVALID !== 1'b0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: WREADY=%b BVALID=%b finish=%b expected 0 0 0", WREADY, BVALID, finish);
        end
        checks++;
        if (BID !== 8'h00 || BRESP !== 2'b00) begin
            errors++;
            $display("FAIL reset_b: BID=%h BRESP=%b expected 00 00", BID, BRESP);
        end
        checks++;
        if (sram_web !== 4'hF || sram_addr !== 14'h0 || sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_sram: web=%h addr=%h wdata=%h expected F 0000 00000000", sram_web, sram_addr, sram_wdata);
        end
        @(negedge clock);
        reset = 1'b1;
        // W must not be taken while idle.
        WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
        #1;
        checks++;
        if (WREADY !== 1'b0 || sram_web !== 4'hF) begin
            errors++;
            $display("FAIL idle_no_w: WREADY=%b web=%h expected 0 F", WREADY, sram_web);
        end
        WVALID = 1'b0;
        checks++;
        if (AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL idle_awready_grant: got %b expected 1", AWREADY);
        end
        grant = 1'b0;
        #1;
        checks++;
        if (AWREADY !== 1'b0) begin
            errors++;
            $display("FAIL idle_awready_nogrant: got %b expected 0", AWREADY);
        end
        grant = 1'b1;
    endtask

    task automatic test_incr;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        int waited;
        send_aw(8'h5A, 32'h0000_0100, 4'd3, 3'd2, INCR, ok);
        checks++;
        if (ok !== 1'b1 || AWREADY !== 1'b0) begin
            errors++;
            $display("FAIL incr_aw: accepted=%b AWREADY_in_data=%b expected 1 0", ok, AWREADY);
        end
        for (int i = 0; i < 4; i++) begin
            send_w(32'hCAFE_0000 + 32'(i), 4'hF, i == 3, rdy, a, web, wd);
            checks++;
            if (rdy !== 1'b1 || a !== 14'h40 + 14'(i) || web !== 4'h0 || wd !== 32'hCAFE_0000 + 32'(i)) begin
                errors++;
                $display("FAIL incr_beat%0d: rdy=%b addr=%h web=%h wdata=%h expected 1 %h 0 %h",
                         i, rdy, a, web, wd, 14'h40 + 14'(i), 32'hCAFE_0000 + 32'(i));
            end
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || waited != 0 || bid !== 8'h5A || bresp !== 2'b00 || fin !== 1'b1) begin
            errors++;
            $display("FAIL incr_b: got=%b wait=%0d BID=%h BRESP=%b finish=%b expected 1 0 5a 00 1",
                     got, waited, bid, bresp, fin);
        end
        #1;
        checks++;
        if (BVALID !== 1'b0 || finish !== 1'b0 || AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL incr_idle: BVALID=%b finish=%b AWREADY=%b expected 0 0 1", BVALID, finish, AWREADY);
        end
    endtask

    task automatic test_fixed;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [3:0] strb [3];
        logic [3:0] exp_web [3];
        int waited;
        strb    = '{4'h1, 4'h2, 4'h4};
        exp_web = '{4'hE, 4'hD, 4'hB};
        send_aw(8'h11, 32'h0000_0020, 4'd2, 3'd2, FIXED, ok);
        for (int i = 0; i < 3; i++) begin
            send_w(32'h1111_1111 * 32'(i + 1), strb[i], i == 2, rdy, a, web, wd);
            checks++;
            if (a !== 14'h08 || web !== exp_web[i]) begin
                errors++;
                $display("FAIL fixed_beat%0d: addr=%h web=%h expected 0008 %h", i, a, web, exp_web[i]);
            end
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || bid !== 8'h11 || bresp !== 2'b00 || fin !== 1'b1) begin
            errors++;
            $display("FAIL fixed_b: got=%b BID=%h BRESP=%b finish=%b expected 1 11 00 1", got, bid, bresp, fin);
        end
    endtask

    task automatic test_wrap;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [13:0] exp_a [4];
        int waited;
        exp_a = '{14'h0E, 14'h0F, 14'h0C, 14'h0D};
        send_aw(8'h22, 32'h0000_0038, 4'd3, 3'd2, WRAP, ok);
        for (int i = 0; i < 4; i++) begin
            send_w(32'h2200_0000 + 32'(i), 4'hF, i == 3, rdy, a, web, wd);
            checks++;
`ifdef AXI_WRAP_BURST_EN
            if (a !== exp_a[i] || web !== 4'h0) begin
                errors++;
                $display("FAIL wrap_beat%0d: addr=%h web=%h expected %h 0", i, a, web, exp_a[i]);
            end
`else
            if (web !== 4'hF) begin
                errors++;
                $display("FAIL wrap_disabled_beat%0d: web=%h expected F (addr %h unused)", i, web, exp_a[i]);
            end
`endif
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
`ifdef AXI_WRAP_BURST_EN
        if (got !== 1'b1 || bid !== 8'h22 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL wrap_b: got=%b BID=%h BRESP=%b expected 1 22 00", got, bid, bresp);
        end
`else
        if (got !== 1'b1 || bid !== 8'h22 || bresp !== 2'b10) begin
            errors++;
            $display("FAIL wrap_disabled_b: got=%b BID=%h BRESP=%b expected 1 22 10", got, bid, bresp);
        end
`endif
    endtask

    task automatic test_early_wlast;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        int waited;
        send_aw(8'h33, 32'h0000_0200, 4'd3, 3'd2, INCR, ok);
        for (int i = 0; i < 2; i++) begin
            send_w(32'h3300_0000 + 32'(i), 4'hF, i == 1, rdy, a, web, wd);
            checks++;
            if (a !== 14'h80 + 14'(i) || web !== 4'h0) begin
                errors++;
                $display("FAIL early_beat%0d: addr=%h web=%h expected %h 0", i, a, web, 14'h80 + 14'(i));
            end
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || waited != 0 || bid !== 8'h33 || bresp !== 2'b10) begin
            errors++;
            $display("FAIL early_b: got=%b wait=%0d BID=%h BRESP=%b expected 1 0 33 10", got, waited, bid, bresp);
        end
    endtask

    task automatic test_missing_wlast;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [3:0] exp_web [4];
        int waited;
        exp_web = '{4'h0, 4'h0, 4'hF, 4'hF};
        send_aw(8'h44, 32'h0000_0300, 4'd1, 3'd2, INCR, ok);
        for (int i = 0; i < 4; i++) begin
            send_w(32'h4400_0000 + 32'(i), 4'hF, i == 3, rdy, a, web, wd);
            checks++;
            if (rdy !== 1'b1 || web !== exp_web[i]) begin
                errors++;
                $display("FAIL missing_beat%0d: rdy=%b web=%h expected 1 %h", i, rdy, web, exp_web[i]);
            end
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || bid !== 8'h44 || bresp !== 2'b10) begin
            errors++;
            $display("FAIL missing_b: got=%b BID=%h BRESP=%b expected 1 44 10", got, bid, bresp);
        end
    endtask

    task automatic test_bad_request;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        int waited;
        // Out of bank.
        send_aw(8'h55, 32'h0001_0000, 4'd0, 3'd2, INCR, ok);
        send_w(32'h5555_5555, 4'hF, 1'b1, rdy, a, web, wd);
        checks++;
        if (web !== 4'hF) begin
            errors++;
            $display("FAIL oob_web: got %h expected F", web);
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || bid !== 8'h55 || bresp !== 2'b10) begin
            errors++;
            $display("FAIL oob_b: got=%b BID=%h BRESP=%b expected 1 55 10", got, bid, bresp);
        end
        // Beat size wider than the bus.
        send_aw(8'h66, 32'h0000_0040, 4'd0, 3'd3, INCR, ok);
        send_w(32'h6666_6666, 4'hF, 1'b1, rdy, a, web, wd);
        checks++;
        if (web !== 4'hF) begin
            errors++;
            $display("FAIL size_web: got %h expected F", web);
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || bid !== 8'h66 || bresp !== 2'b10) begin
            errors++;
            $display("FAIL size_b: got=%b BID=%h BRESP=%b expected 1 66 10", got, bid, bresp);
        end
    endtask

    task automatic test_bready_stall;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        int waited;
        send_aw(8'h77, 32'h0000_0004, 4'd0, 3'd2, INCR, ok);
        send_w(32'h7777_7777, 4'h3, 1'b1, rdy, a, web, wd);
        checks++;
        if (a !== 14'h0001 || web !== 4'hC) begin
            errors++;
            $display("FAIL stall_beat: addr=%h web=%h expected 0001 C", a, web);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            checks++;
            if (BVALID !== 1'b1 || BID !== 8'h77 || BRESP !== 2'b00 || finish !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: BVALID=%b BID=%h BRESP=%b finish=%b expected 1 77 00 0",
                         i, BVALID, BID, BRESP, finish);
            end
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || bid !== 8'h77 || bresp !== 2'b00 || fin !== 1'b1) begin
            errors++;
            $display("FAIL stall_b: got=%b BID=%h BRESP=%b finish=%b expected 1 77 00 1", got, bid, bresp, fin);
        end
    endtask

    task automatic test_grant_drop;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        int waited;
        send_aw(8'h99, 32'h0000_0010, 4'd1, 3'd2, INCR, ok);
        grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_w(32'h9900_0000 + 32'(i), 4'hF, i == 1, rdy, a, web, wd);
            checks++;
            if (a !== 14'h4 + 14'(i) || web !== 4'h0) begin
                errors++;
                $display("FAIL grant_beat%0d: addr=%h web=%h expected %h 0", i, a, web, 14'h4 + 14'(i));
            end
        end
        get_b(got, waited, bid, bresp, fin);
        checks++;
        if (got !== 1'b1 || bresp !== 2'b00 || fin !== 1'b1 || AWREADY !== 1'b0) begin
            errors++;
            $display("FAIL grant_b: got=%b BRESP=%b finish=%b AWREADY=%b expected 1 00 1 0",
                     got, bresp, fin, AWREADY);
        end
        grant = 1'b1;
    endtask

    task automatic test_reset_mid_burst;
        logic ok, rdy, seen_b;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        send_aw(8'h88, 32'h0000_0000, 4'd3, 3'd2, INCR, ok);
        send_w(32'h8888_8888, 4'hF, 1'b0, rdy, a, web, wd);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (WREADY !== 1'b0 || BVALID !== 1'b0 || sram_web !== 4'hF || BID !== 8'h00) begin
            errors++;
            $display("FAIL midreset_now: WREADY=%b BVALID=%b web=%h BID=%h expected 0 0 F 00",
                     WREADY, BVALID, sram_web, BID);
        end
        @(negedge clock);
        reset = 1'b1;
        seen_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            if (BVALID) seen_b = 1'b1;
        end
        checks++;
        if (seen_b !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: sawB=%b AWREADY=%b WREADY=%b expected 0 1 0", seen_b, AWREADY, WREADY);
        end
    endtask

    task automatic test_back_to_back;
        logic ok, rdy, got, fin;
        logic [13:0] a;
        logic [3:0] web;
        logic [31:0] wd;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [31:0] addrs [2];
        logic [13:0] exp_a [2];
        int waited;
        addrs = '{32'h0000_FFFC, 32'h0000_0000};
        exp_a = '{14'h3FFF, 14'h0000};
        for (int t = 0; t < 2; t++) begin
            send_aw(8'h9A + 8'(t), addrs[t], 4'd0, 3'd2, INCR, ok);
            send_w(32'hB0B0_0000 + 32'(t), 4'hF, 1'b1, rdy, a, web, wd);
            checks++;
            if (ok !== 1'b1 || a !== exp_a[t] || web !== 4'h0) begin
                errors++;
                $display("FAIL b2b%0d_beat: ok=%b addr=%h web=%h expected 1 %h 0", t, ok, a, web, exp_a[t]);
            end
            get_b(got, waited, bid, bresp, fin);
            checks++;
            if (got !== 1'b1 || bid !== 8'h9A + 8'(t) || bresp !== 2'b00 || fin !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d_b: got=%b BID=%h BRESP=%b finish=%b expected 1 %h 00 1",
                         t, got, bid, bresp, fin, 8'h9A + 8'(t));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset;
        test_incr;
        test_fixed;
        test_wrap;
        test_early_wlast;
        test_missing_wlast;
        test_bad_request;
        test_bready_stall;
        test_grant_drop;
        test_reset_mid_burst;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
